// File: rtl/octavo_io_pkg.sv
// Shared definitions for Octavo I/O port peripherals: EF flag polarity and a
// constant-foldable clog2 used to size pointers from a depth parameter.
package octavo_io_pkg;

  // EF flags are active-high: 1 means the CPU side must stall.
  localparam logic EF_FULL  = 1'b1;
  localparam logic EF_EMPTY = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rest;
    result = 0;
    rest   = (value > 0) ? value - 1 : 0;
    while (rest > 0) begin
      result++;
      rest = rest >> 1;
    end
    return result;
  endfunction

endpackage : octavo_io_pkg

// File: rtl/octavo_io_fifo_mem.sv
// FIFO storage: DEPTH x WORD_WIDTH register array with one synchronous write
// port and one asynchronous (combinational) read port for fall-through reads.
module octavo_io_fifo_mem #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WORD_WIDTH-1:0] rd_data_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : octavo_io_fifo_mem

// File: rtl/octavo_io_port_fifo.sv
// FIFO endpoint mating with one Octavo I/O port pair: the CPU write port pushes,
// the CPU read port pops, and the EF flags throttle each side.
module octavo_io_port_fifo
  import octavo_io_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_wren,
  input  logic [WORD_WIDTH-1:0] io_out,
  output logic                  io_out_EF,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_in,
  output logic                  io_in_EF,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full;
  logic empty;
  logic push_acc;
  logic pop_acc;

  // Accept decisions look only at pre-edge occupancy, so a full FIFO drops a
  // simultaneous push and an empty one ignores a simultaneous pop.
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign push_acc = io_wren && !full;
  assign pop_acc  = io_rden && !empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (io_wren & full);
    underflow_d = underflow_q | (io_rden & empty);

    if (push_acc) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (pop_acc) begin
      rp_d = rp_q + PTR_ONE;
    end

    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  octavo_io_fifo_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (push_acc),
    .wr_addr_i (wp_q),
    .wr_data_i (io_out),
    .rd_addr_i (rp_q),
    .rd_data_o (io_in)
  );

  // Flags decode the count register only, so they carry no path from the strobes.
  assign io_in_EF  = empty ? EF_EMPTY : ~EF_EMPTY;
  assign io_out_EF = full  ? EF_FULL  : ~EF_FULL;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : octavo_io_port_fifo

// File: tb/tb_octavo_io_port_fifo.sv
// Directed self-checking bench for octavo_io_port_fifo at DEPTH=4, WORD_WIDTH=36.
module tb_octavo_io_port_fifo;

  localparam int unsigned WORD_WIDTH = 36;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned ADDR_WIDTH = 2;

  logic                  clock;
  logic                  reset;
  logic                  io_wren;
  logic [WORD_WIDTH-1:0] io_out;
  logic                  io_out_EF;
  logic                  io_rden;
  logic [WORD_WIDTH-1:0] io_in;
  logic                  io_in_EF;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  int checks;
  int errors;

  octavo_io_port_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_wren   (io_wren),
    .io_out    (io_out),
    .io_out_EF (io_out_EF),
    .io_rden   (io_rden),
    .io_in     (io_in),
    .io_in_EF  (io_in_EF),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WORD_WIDTH-1:0] observed,
                       input logic [WORD_WIDTH-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    io_wren = 1'b0;
    io_rden = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    io_wren = 1'b0;
    io_rden = 1'b0;
    io_out  = '0;

    // Reset state
    #3;
    check("rst_count", count, 0);
    check("rst_in_ef", io_in_EF, 1);
    check("rst_out_ef", io_out_EF, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    step();
    reset = 1'b0;
    step();

    // Latency: push 0xABC, visible right after the edge; pop next edge
    io_wren = 1'b1; io_out = 36'hABC;
    step();
    idle();
    check("lat_in", io_in, 36'hABC);
    check("lat_in_ef", io_in_EF, 0);
    check("lat_count", count, 1);
    io_rden = 1'b1;
    step();
    idle();
    check("lat_pop_in_ef", io_in_EF, 1);
    check("lat_pop_count", count, 0);

    // Fill then drain
    for (int k = 1; k <= 4; k++) begin
      io_wren = 1'b1; io_out = WORD_WIDTH'(k);
      step();
      check("fill_count", count, WORD_WIDTH'(k));
      check("fill_out_ef", io_out_EF, (k == 4) ? 1 : 0);
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      check("drain_head", io_in, WORD_WIDTH'(k));
      io_rden = 1'b1;
      step();
      check("drain_out_ef", io_out_EF, 0);
    end
    idle();
    check("drain_in_ef", io_in_EF, 1);
    check("drain_count", count, 0);
    check("drain_ovf", overflow, 0);

    // Wrap-around with count held at 2
    io_wren = 1'b1; io_out = 36'h100;
    step();
    io_out = 36'h101;
    step();
    for (int k = 36'h102; k < 36'h102 + 10; k++) begin
      io_wren = 1'b1; io_rden = 1'b1; io_out = WORD_WIDTH'(k);
      check("wrap_head", io_in, WORD_WIDTH'(k - 2));
      step();
      check("wrap_count", count, 2);
    end
    idle();
    check("wrap_tail0", io_in, 36'h10A);
    io_rden = 1'b1;
    step();
    check("wrap_tail1", io_in, 36'h10B);
    step();
    idle();
    check("wrap_empty", io_in_EF, 1);

    // Full with push and pop both requested
    for (int k = 1; k <= 4; k++) begin
      io_wren = 1'b1; io_out = WORD_WIDTH'(k);
      step();
    end
    check("full_pre_count", count, 4);
    io_wren = 1'b1; io_rden = 1'b1; io_out = 36'h99;
    step();
    idle();
    check("full_pp_count", count, 3);
    check("full_pp_ovf", overflow, 1);
    check("full_pp_head", io_in, 36'h2);
    check("full_pp_out_ef", io_out_EF, 0);
    for (int k = 2; k <= 4; k++) begin
      check("full_drain_head", io_in, WORD_WIDTH'(k));
      io_rden = 1'b1;
      step();
    end
    idle();
    check("full_drain_count", count, 0);
    check("ovf_sticky", overflow, 1);

    // Empty with push and pop both requested
    io_wren = 1'b1; io_rden = 1'b1; io_out = 36'h55;
    step();
    idle();
    check("empty_pp_count", count, 1);
    check("empty_pp_head", io_in, 36'h55);
    check("empty_pp_unf", underflow, 1);
    check("empty_pp_in_ef", io_in_EF, 0);
    io_wren = 1'b1; io_out = 36'h66;
    step();
    idle();
    check("pre_rst_count", count, 2);

    // Asynchronous reset mid-traffic, no clock edge in between
    io_wren = 1'b1; io_out = 36'h77;
    #2;
    reset = 1'b1;
    #1;
    check("amid_rst_count", count, 0);
    check("amid_rst_in_ef", io_in_EF, 1);
    check("amid_rst_out_ef", io_out_EF, 0);
    check("amid_rst_ovf", overflow, 0);
    check("amid_rst_unf", underflow, 0);
    step();
    check("hold_rst_count", count, 0);
    idle();
    reset = 1'b0;
    step();
    check("post_rst_in_ef", io_in_EF, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_octavo_io_port_fifo
